uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 197 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a circular TX FIFO.
// Frames are start bit, DATA_W data bits LSB first, optional parity bit and STOP_BITS stop bits.
// The baud divisor and parity mode are latched when each frame starts.
module uart_tx_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          tx_en_i,
  input  logic [15:0]                   baud_div_i,
  input  logic [1:0]                    parity_i,
  input  logic                          wr_valid_i,
  input  logic [DATA_W-1:0]             wr_data_i,
  output logic                          wr_ready_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
  output logic                          busy_o,
  output logic                          tx_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BIT_W = 4;
  localparam int unsigned DIV_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_cnt;

  state_t            r_state;
  logic              r_tx;
  logic              r_busy;
  logic [DIV_W-1:0]  r_baud;
  logic [DIV_W-1:0]  r_div;
  logic [BIT_W-1:0]  r_bit;
  logic [DATA_W-1:0] r_shift;
  logic              r_par_en;
  logic              r_par_bit;

  logic              w_push;
  logic              w_pop;
  logic              w_bit_end;
  logic              w_last_stop;
  logic              w_can_start;
  logic [DIV_W-1:0]  w_div_eff;
  logic [DATA_W-1:0] w_head;
  logic              w_par_en;
  logic              w_par_bit;

  // FIFO handshake and frame-start decode
  assign wr_ready_o  = (r_cnt < CNT_W'(FIFO_DEPTH));
  assign w_push      = wr_valid_i & wr_ready_o & ~rst_i;
  assign w_bit_end   = (r_baud == '0);
  assign w_last_stop = (r_bit == BIT_W'(STOP_BITS - 1));
  assign w_can_start = tx_en_i & (r_cnt != '0);
  assign w_pop       = w_can_start &
                       ((r_state == IDLE) | ((r_state == STOP) & w_bit_end & w_last_stop));

  // Values captured at frame start: divisor clamped to 1, parity from the head entry
  assign w_div_eff = (baud_div_i == '0) ? DIV_W'(1) : baud_div_i;
  assign w_head    = r_mem[r_rptr];
  assign w_par_en  = (parity_i == 2'b01) | (parity_i == 2'b10);
  assign w_par_bit = (^w_head) ^ (parity_i == 2'b01);

  assign fifo_cnt_o = r_cnt;
  assign busy_o     = r_busy;
  assign tx_o       = r_tx;

  // FIFO storage; pointer reset makes stale contents unreachable
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= wr_data_i;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Transmit FSM with registered line and busy outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_baud    <= '0;
      r_div     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
    end else if (w_pop) begin
      // New frame from IDLE or straight out of the last stop bit
      r_state   <= START;
      r_tx      <= 1'b0;
      r_busy    <= 1'b1;
      r_shift   <= w_head;
      r_div     <= w_div_eff;
      r_baud    <= w_div_eff - DIV_W'(1);
      r_bit     <= '0;
      r_par_en  <= w_par_en;
      r_par_bit <= w_par_bit;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
        end
        START: begin
          if (w_bit_end) begin
            r_state <= DATA;
            r_tx    <= r_shift[0];
            r_baud  <= r_div - DIV_W'(1);
            r_bit   <= '0;
          end else begin
            r_baud <= r_baud - DIV_W'(1);
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_baud <= r_div - DIV_W'(1);
            if (r_bit == BIT_W'(DATA_W - 1)) begin
              r_bit <= '0;
              if (r_par_en) begin
                r_state <= PARITY;
                r_tx    <= r_par_bit;
              end else begin
                r_state <= STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit   <= r_bit + BIT_W'(1);
              r_shift <= {1'b0, r_shift[DATA_W-1:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud - DIV_W'(1);
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_state <= STOP;
            r_tx    <= 1'b1;
            r_baud  <= r_div - DIV_W'(1);
            r_bit   <= '0;
          end else begin
            r_baud <= r_baud - DIV_W'(1);
          end
        end
        STOP: begin
          if (w_bit_end) begin
            if (w_last_stop) begin
              r_state <= IDLE;
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
              r_bit   <= '0;
            end else begin
              r_bit  <= r_bit + BIT_W'(1);
              r_baud <= r_div - DIV_W'(1);
            end
          end else begin
            r_baud <= r_baud - DIV_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: table of single frames plus hand-written
// sequences for FIFO fill/drain, push+pop with wrap, reset mid-frame and two stop bits.
module tb_uart_tx_fifo;

  typedef struct {
    logic        sel;      // 0: one-stop-bit instance, 1: two-stop-bit instance
    logic [7:0]  data;
    logic [1:0]  par;
    logic [15:0] div;
    int          nbits;    // bit times per frame
    logic [11:0] frame;    // expected line level per bit time, first bit in [0]
    int          blen;     // expected busy length in cycles
  } vec_t;

  logic        clk;
  logic        rst;
  logic        tx_en;
  logic [15:0] div;
  logic [1:0]  par;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        sel;

  logic        rdy1, rdy2, busy1, busy2, tx1, tx2;
  logic [3:0]  cnt1, cnt2;
  logic        obs_rdy, obs_busy, obs_tx;
  logic [3:0]  obs_cnt;

  int checks;
  int failures;

  vec_t vecs [8];
  vec_t vrst;
  logic [7:0] sb [8];

  uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(8), .STOP_BITS(1)) u_dut1 (
    .clk_i      (clk),
    .rst_i      (rst),
    .tx_en_i    (tx_en),
    .baud_div_i (div),
    .parity_i   (par),
    .wr_valid_i (wr_valid & ~sel),
    .wr_data_i  (wr_data),
    .wr_ready_o (rdy1),
    .fifo_cnt_o (cnt1),
    .busy_o     (busy1),
    .tx_o       (tx1)
  );

  uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(8), .STOP_BITS(2)) u_dut2 (
    .clk_i      (clk),
    .rst_i      (rst),
    .tx_en_i    (tx_en),
    .baud_div_i (div),
    .parity_i   (par),
    .wr_valid_i (wr_valid & sel),
    .wr_data_i  (wr_data),
    .wr_ready_o (rdy2),
    .fifo_cnt_o (cnt2),
    .busy_o     (busy2),
    .tx_o       (tx2)
  );

  assign obs_rdy  = sel ? rdy2  : rdy1;
  assign obs_busy = sel ? busy2 : busy1;
  assign obs_tx   = sel ? tx2   : tx1;
  assign obs_cnt  = sel ? cnt2  : cnt1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Write one byte with tx_en=1 on an idle, empty instance and check the whole frame
  task automatic apply_vec(input string name, input vec_t v);
    int deff;
    int i;
    int errs;
    int first_bad;
    logic exp_bit;
    @(negedge clk);
    sel      = v.sel;
    wr_data  = v.data;
    par      = v.par;
    div      = v.div;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    check({name, "_line_before_start"}, 32'(obs_tx), 32'd1);
    check({name, "_cnt_after_write"}, 32'(obs_cnt), 32'd1);
    @(negedge clk);
    // Mid-frame changes must not affect the frame in flight
    div = 16'd7;
    par = 2'b01;
    deff = (v.div == 16'd0) ? 1 : int'(v.div);
    i = 0;
    errs = 0;
    first_bad = -1;
    while (obs_busy && i < 2000) begin
      exp_bit = (i < v.nbits * deff) ? v.frame[i / deff] : 1'b1;
      if (obs_tx !== exp_bit) begin
        errs++;
        if (first_bad < 0) first_bad = i;
      end
      i++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 32'(i), 32'(v.blen));
    check({name, "_bad_line_cycles"}, 32'(errs), 32'd0);
    check({name, "_line_idle_after"}, 32'(obs_tx), 32'd1);
  endtask

  // Check back-to-back frames at one cycle per bit, no parity, on instance 1
  task automatic stream_check(input string name, input logic [7:0] exp [8], input int n);
    int i;
    int errs;
    logic [9:0] f;
    i = 0;
    errs = 0;
    while (busy1 && i < 2000) begin
      if (i < n * 10) begin
        f = {1'b1, exp[i / 10], 1'b0};
        if (tx1 !== f[i % 10]) errs++;
      end else if (tx1 !== 1'b1) begin
        errs++;
      end
      i++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 32'(i), 32'(n * 10));
    check({name, "_bad_line_cycles"}, 32'(errs), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    tx_en    = 1'b0;
    div      = 16'd4;
    par      = 2'b00;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    sel      = 1'b0;

    vecs[0] = '{1'b0, 8'hA5, 2'b00, 16'd4, 10, 12'h34A, 40};
    vecs[1] = '{1'b0, 8'h07, 2'b10, 16'd4, 11, 12'h60E, 44};
    vecs[2] = '{1'b0, 8'h07, 2'b01, 16'd4, 11, 12'h40E, 44};
    vecs[3] = '{1'b0, 8'h3C, 2'b11, 16'd2, 10, 12'h278, 20};
    vecs[4] = '{1'b0, 8'hFF, 2'b10, 16'd0, 11, 12'h5FE, 11};
    vecs[5] = '{1'b0, 8'h00, 2'b01, 16'd1, 11, 12'h600, 11};
    vecs[6] = '{1'b0, 8'h5A, 2'b00, 16'd3, 10, 12'h2B4, 30};
    vecs[7] = '{1'b1, 8'h81, 2'b00, 16'd0, 11, 12'h702, 11};
    vrst    = '{1'b0, 8'hC3, 2'b10, 16'd2, 11, 12'h586, 22};

    // Reset values, and a write during reset is ignored
    @(negedge clk);
    check("rst_tx", 32'(tx1), 32'd1);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_cnt", 32'(cnt1), 32'd0);
    check("rst_ready", 32'(rdy1), 32'd1);
    wr_data  = 8'h99;
    wr_valid = 1'b1;
    @(negedge clk);
    check("rst_write_ignored", 32'(cnt1), 32'd0);
    wr_valid = 1'b0;
    rst      = 1'b0;
    tx_en    = 1'b1;

    // Single-frame table
    for (int k = 0; k < 8; k++) begin
      apply_vec($sformatf("vec%0d", k), vecs[k]);
    end

    // Fill with transmit disabled, 9th write dropped, then drain back-to-back
    @(negedge clk);
    sel   = 1'b0;
    tx_en = 1'b0;
    div   = 16'd1;
    par   = 2'b00;
    for (int k = 0; k < 9; k++) begin
      wr_data  = 8'(8'h10 + k);
      wr_valid = 1'b1;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    check("full_cnt", 32'(cnt1), 32'd8);
    check("full_ready", 32'(rdy1), 32'd0);
    check("full_busy", 32'(busy1), 32'd0);
    tx_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 8; k++) sb[k] = 8'(8'h10 + k);
    stream_check("drain8", sb, 8);
    check("drain_cnt", 32'(cnt1), 32'd0);
    check("drain_ready", 32'(rdy1), 32'd1);

    // Push and pop on the same edge at count 3, across the pointer wrap
    tx_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wr_data  = 8'(8'h31 + k);
      wr_valid = 1'b1;
      @(negedge clk);
    end
    check("pp_cnt_before", 32'(cnt1), 32'd3);
    wr_data = 8'h34;
    tx_en   = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    check("pp_cnt_after", 32'(cnt1), 32'd3);
    for (int k = 0; k < 8; k++) sb[k] = 8'(8'h31 + k);
    stream_check("pushpop", sb, 4);

    // Reset in the middle of DATA bit 1 of 0x55 with another byte queued
    @(negedge clk);
    sel      = 1'b0;
    div      = 16'd4;
    par      = 2'b00;
    wr_data  = 8'h55;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_data = 8'h66;
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_tx_low", 32'(tx1), 32'd0);
    check("mid_cnt", 32'(cnt1), 32'd1);
    check("mid_busy", 32'(busy1), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_tx", 32'(tx1), 32'd1);
    check("async_rst_busy", 32'(busy1), 32'd0);
    check("async_rst_cnt", 32'(cnt1), 32'd0);
    check("async_rst_ready", 32'(rdy1), 32'd1);
    wr_data  = 8'hEE;
    wr_valid = 1'b1;
    @(negedge clk);
    check("rst2_write_ignored", 32'(cnt1), 32'd0);
    wr_valid = 1'b0;
    rst      = 1'b0;
    apply_vec("after_rst", vrst);
    check("after_rst_cnt", 32'(cnt1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
